// File: rtl/nb_ctrl_pkg.sv
// Shared definitions for the training/inference controller: opcodes, instruction
// layout and sequencer states.
package nb_ctrl_pkg;

    localparam int OP_W      = 4;
    localparam int PARAM_A_W = 4;
    localparam int PARAM_B_W = 4;
    localparam int ADDR_W    = 8;

    localparam int OP_HALT           = 0;
    localparam int SET_ACT_DENSE     = 1;
    localparam int SET_COST          = 2;
    localparam int LOAD_WEIGHT       = 3;
    localparam int LOAD_INPUT_LABEL  = 4;
    localparam int SET_LEARNING_RATE = 5;
    localparam int UPDATE_WEIGHT     = 6;
    localparam int STALL             = 7;
    localparam int LOAD_Z            = 8;
    localparam int OP_MAX            = 8;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [PARAM_A_W-1:0] param_a;
        logic [PARAM_B_W-1:0] param_b;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/code_line_counter.sv
// Cycles-on-current-line counter: synchronous clear, increment enable, saturates at all-ones.
module code_line_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/code_sequencer.sv
// Program sequencer: fetches one instruction per code line and steps the decoder.
// state | meaning
// IDLE  | waiting for start       FETCH | imem request outstanding
// EXEC  | decoder running line    DONE  | program finished, pc holds last line
module code_sequencer
    import nb_ctrl_pkg::*;
#(
    parameter int OP_SIZE      = OP_W,
    parameter int PARAM_A_SIZE = PARAM_A_W,
    parameter int PARAM_B_SIZE = PARAM_B_W,
    parameter int CODE_ADDR_W  = ADDR_W
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       abort,
    input  logic [CODE_ADDR_W-1:0]                     program_len,
    output logic                                       imem_req,
    output logic [CODE_ADDR_W-1:0]                     imem_addr,
    input  logic                                       imem_valid,
    input  logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] imem_data,
    output logic [OP_SIZE-1:0]                         op,
    output logic [PARAM_A_SIZE-1:0]                    param_a,
    output logic [PARAM_B_SIZE-1:0]                    param_b,
    output logic [PARAM_A_SIZE+PARAM_B_SIZE-1:0]       param_c,
    output logic [31:0]                                code_count,
    output logic                                       enable,
    input  logic                                       ctrl_reset,
    input  logic                                       ctrl_code_active,
    input  logic                                       ctrl_code_reset,
    output logic [CODE_ADDR_W-1:0]                     pc,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       error
);

    seq_state_t               state_q, state_d;
    logic [CODE_ADDR_W-1:0]   pc_q, pc_d, len_q, len_d;
    logic [OP_SIZE-1:0]       op_q;
    logic [PARAM_A_SIZE-1:0]  pa_q;
    logic [PARAM_B_SIZE-1:0]  pb_q;
    logic                     err_q, err_d;
    logic                     load_instr, cnt_clr, cnt_inc;
    logic                     in_exec, op_halt, op_illegal;

    assign op_halt    = (32'(op_q) == OP_HALT);
    assign op_illegal = (32'(op_q) > OP_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            op_q    <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            err_q   <= err_d;
            if (load_instr) begin
                {op_q, pa_q, pb_q} <= imem_data;
            end
        end
    end

    // Counter is held at zero everywhere except while a line keeps executing.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        err_d      = err_q;
        load_instr = 1'b0;
        cnt_clr    = 1'b1;
        cnt_inc    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            pc_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pc_d    = '0;
                        len_d   = program_len;
                        err_d   = 1'b0;
                        state_d = (program_len == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        load_instr = 1'b1;
                        state_d    = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_halt) begin
                        state_d = ST_DONE;
                    end else if (op_illegal) begin
                        // Decoder never finishes an unknown op; bail out instead of hanging.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (ctrl_code_reset) begin
                        pc_d    = '0;
                        state_d = ST_FETCH;
                    end else if (ctrl_code_active) begin
                        if ((pc_q + CODE_ADDR_W'(1)) == len_q) begin
                            state_d = ST_DONE;
                        end else begin
                            pc_d    = pc_q + CODE_ADDR_W'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        cnt_clr = ctrl_reset;
                        cnt_inc = !ctrl_reset;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    code_line_counter u_line_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (code_count)
    );

    assign in_exec   = (state_q == ST_EXEC);
    assign enable    = in_exec;
    assign op        = in_exec ? op_q : '0;
    assign param_a   = in_exec ? pa_q : '0;
    assign param_b   = in_exec ? pb_q : '0;
    assign param_c   = {param_a, param_b};
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = imem_req ? pc_q : '0;
    assign pc        = pc_q;
    assign busy      = imem_req || in_exec;
    assign done      = (state_q == ST_DONE);
    assign error     = err_q;

endmodule

// File: tb/tb_code_sequencer.sv
// Scoreboard bench for code_sequencer: random programs against a line-level reference model.
module tb_code_sequencer;
    import nb_ctrl_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0]  program_len = '0;
    logic        imem_req, imem_valid = 1'b0;
    logic [7:0]  imem_addr;
    logic [11:0] imem_data = '0;
    logic [3:0]  op, param_a, param_b;
    logic [7:0]  param_c, pc;
    logic [31:0] code_count;
    logic        enable, busy, done, error;
    logic        ctrl_reset = 1'b0, force_active = 1'b0, force_reset = 1'b0;
    logic        dec_active, ctrl_code_active, ctrl_code_reset;
    logic [72:0] all_outs;

    typedef struct packed {
        logic        kind;   // 0 = EXEC cycle, 1 = program end
        logic [7:0]  pc;
        logic [3:0]  op, a, b;
        logic [7:0]  c;
        logic [31:0] cnt;
        logic        err;
    } rec_t;

    rec_t   exp_q[$];
    instr_t mem[256];
    int     tests = 0, fails = 0, lat = -1;
    logic   sb_on = 1'b0, mem_on = 1'b1, done_prev = 1'b0;

    always #5 clk = ~clk;

    code_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .program_len(program_len),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .op(op), .param_a(param_a), .param_b(param_b), .param_c(param_c), .code_count(code_count),
        .enable(enable), .ctrl_reset(ctrl_reset), .ctrl_code_active(ctrl_code_active),
        .ctrl_code_reset(ctrl_code_reset), .pc(pc), .busy(busy), .done(done), .error(error)
    );

    // Decoder stand-in: a line finishes on the cycle its code_count reaches its cost.
    function automatic int line_cost(logic [3:0] o, logic [7:0] c);
        case (int'(o))
            LOAD_WEIGHT, LOAD_INPUT_LABEL, UPDATE_WEIGHT, LOAD_Z: return 3;
            STALL:                                                return int'(c);
            SET_ACT_DENSE, SET_COST, SET_LEARNING_RATE:           return 0;
            default:                                              return -1;
        endcase
    endfunction

    assign dec_active = enable && (line_cost(op, param_c) >= 0)
                        && (code_count == 32'(line_cost(op, param_c)));
    assign ctrl_code_active = dec_active || force_active;
    assign ctrl_code_reset  = force_reset;
    assign all_outs = {imem_req, imem_addr, op, param_a, param_b, param_c, code_count,
                       enable, pc, busy, done, error};

    function automatic rec_t mk(logic k, logic [7:0] p, logic [3:0] o, logic [3:0] a,
                                logic [3:0] b, logic [31:0] cnt, logic e);
        rec_t r;
        r.kind = k; r.pc = p; r.op = o; r.a = a; r.b = b; r.c = {a, b}; r.cnt = cnt; r.err = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: walk the program line by line, one record per expected EXEC cycle.
    task automatic model_prog(input int len);
        int line;
        instr_t in;
        int n;
        line = 0;
        if (len == 0) begin
            exp_q.push_back(mk(1'b1, 8'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0));
            return;
        end
        forever begin
            in = mem[line];
            n  = line_cost(in.op, {in.param_a, in.param_b});
            if (n < 0) begin
                exp_q.push_back(mk(1'b0, 8'(line), in.op, in.param_a, in.param_b, 32'd0, 1'b0));
                exp_q.push_back(mk(1'b1, 8'(line), 4'd0, 4'd0, 4'd0, 32'd0, in.op != 4'd0));
                return;
            end
            for (int c = 0; c <= n; c++)
                exp_q.push_back(mk(1'b0, 8'(line), in.op, in.param_a, in.param_b, 32'(c), 1'b0));
            if (line + 1 == len) begin
                exp_q.push_back(mk(1'b1, 8'(line), 4'd0, 4'd0, 4'd0, 32'd0, 1'b0));
                return;
            end
            line++;
        end
    endtask

    // Instruction memory: answers each request 1..3 cycles later.
    always @(negedge clk) begin
        if (mem_on) begin
            imem_valid = 1'b0;
            if (imem_req) begin
                if (lat < 0) lat = $urandom_range(1, 3);
                else lat--;
                if (lat == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr];
                    lat        = -1;
                end
            end else begin
                lat = -1;
            end
        end
    end

    // Monitor: every EXEC cycle and every program end is one scoreboard transaction.
    always @(negedge clk) begin
        rec_t obs, e;
        logic ev;
        ev  = 1'b0;
        obs = '0;
        if (enable) begin
            ev = 1'b1;
            obs = mk(1'b0, pc, op, param_a, param_b, code_count, error);
            obs.c = param_c;
        end else if (done && !done_prev) begin
            ev = 1'b1;
            obs = mk(1'b1, pc, op, param_a, param_b, 32'd0, error);
            obs.c = param_c;
        end
        done_prev = done;
        if (ev && sb_on) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected got=%h", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    fails++;
                    $display("FAIL sb_%s got=%h exp=%h", obs.kind ? "end" : "exec", obs, e);
                end
            end
        end
    end

    task automatic run_prog(input int len);
        int cyc;
        model_prog(len);
        @(negedge clk); program_len = 8'(len); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            start = 1'($urandom_range(0, 1));   // must be ignored while busy
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            fails++; tests++;
            $display("FAIL run_timeout got=busy exp=done");
        end
        @(negedge clk);
        check("sb_drain", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    task automatic start_manual(input int len);
        @(negedge clk); program_len = 8'(len); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'(all_outs), 128'd0);
        rst_n = 1'b1;
        sb_on = 1'b1;

        mem[0] = '{4'(SET_COST), 4'd1, 4'd2}; mem[1] = '{4'(OP_HALT), 4'd0, 4'd0};
        run_prog(2);
        mem[0] = '{4'(LOAD_WEIGHT), 4'd0, 4'd2};
        run_prog(1);
        mem[0] = '{4'(STALL), 4'd0, 4'd5};
        run_prog(1);
        mem[0] = '{4'hF, 4'd3, 4'd4};
        run_prog(1);
        check("error_sticky", 128'({error, done}), 128'b11);
        mem[0] = '{4'(SET_COST), 4'd1, 4'd2}; mem[1] = '{4'(OP_HALT), 4'd0, 4'd0};
        run_prog(2);

        // Reset and advance together: reset must win.
        sb_on = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '{4'(SET_COST), 4'(i), 4'd0};
        start_manual(4);
        cyc = 0;
        while (!(enable && pc == 8'd2) && cyc < 200) begin @(negedge clk); cyc++; end
        check("reach_pc2", 128'({enable, pc}), 128'({1'b1, 8'd2}));
        force_reset = 1'b1; force_active = 1'b1;
        @(negedge clk);
        force_reset = 1'b0; force_active = 1'b0;
        check("code_reset_wins", 128'({imem_req, imem_addr, pc, enable}), 128'({1'b1, 8'd0, 8'd0, 1'b0}));
        abort = 1'b1; @(negedge clk); abort = 1'b0;

        // Abort in the middle of a multi-cycle line.
        mem[0] = '{4'(LOAD_Z), 4'd3, 4'd3};
        start_manual(1);
        cyc = 0;
        while (!(enable && code_count == 32'd1) && cyc < 200) begin @(negedge clk); cyc++; end
        check("reach_count1", 128'({enable, code_count}), 128'({1'b1, 32'd1}));
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_idle", 128'({enable, imem_req, busy, done, pc, op, code_count}), 128'd0);

        // Empty program goes straight to DONE.
        start_manual(0);
        check("len0_done", 128'({done, busy, pc, imem_req}), 128'({1'b1, 1'b0, 8'd0, 1'b0}));

        // Reset during a fetch; the late response must be dropped.
        mem_on = 1'b0; imem_valid = 1'b0;
        start_manual(1);
        cyc = 0;
        while (!imem_req && cyc < 20) begin @(negedge clk); cyc++; end
        check("fetch_started", 128'(imem_req), 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_fetch", 128'(all_outs), 128'd0);
        rst_n = 1'b1; imem_valid = 1'b1; imem_data = {4'(LOAD_Z), 8'h21};
        @(negedge clk);
        imem_valid = 1'b0;
        check("late_valid_ignored", 128'(all_outs), 128'd0);
        mem_on = 1'b1;
        done_prev = done;

        sb_on = 1'b1;
        for (int p = 0; p < 25; p++) begin
            int len, r;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 19);
                if (r == 0)      mem[i].op = 4'(OP_HALT);
                else if (r == 1) mem[i].op = 4'($urandom_range(9, 15));
                else             mem[i].op = 4'($urandom_range(1, 8));
                mem[i].param_a = (mem[i].op == 4'(STALL)) ? 4'd0 : 4'($urandom_range(0, 15));
                mem[i].param_b = 4'($urandom_range(0, 15));
            end
            run_prog(len);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
